// File: rtl/fifo_queuing_param.sv
// fifo_queuing_param: parametrised synchronous FIFO with occupancy count, thresholds, sticky errors and flush.
// Define FIFO_QUEUING_FWFT_EN for first-word fall-through DataOut; default is a registered 1-cycle read.
module fifo_queuing_param #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 8,
    parameter int POINTER_WIDTH = 3,
    parameter int AF_LEVEL      = 6,
    parameter int AE_LEVEL      = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   put,
    input  logic                   get,
    input  logic [WIDTH-1:0]       DataIn,
    output logic [WIDTH-1:0]       DataOut,
    output logic                   empty,
    output logic                   QFull,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [POINTER_WIDTH:0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam logic [POINTER_WIDTH:0] DEPTH_C = (POINTER_WIDTH+1)'(DEPTH);
    localparam logic [POINTER_WIDTH:0] AF_C    = (POINTER_WIDTH+1)'(AF_LEVEL);
    localparam logic [POINTER_WIDTH:0] AE_C    = (POINTER_WIDTH+1)'(AE_LEVEL);

    logic [POINTER_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                   overflow_q, overflow_d, underflow_q, underflow_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic                   get_e, put_e;

    // Extra pointer bit distinguishes full from empty, so count is a plain difference.
    assign count        = wr_ptr_q - rd_ptr_q;
    assign empty        = count == '0;
    assign QFull        = count == DEPTH_C;
    assign almost_empty = count <= AE_C;
    assign almost_full  = count >= AF_C;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign get_e = get & ~empty;
    assign put_e = put & (~QFull | get_e);

    always_comb begin
        wr_ptr_d    = clr ? '0 : wr_ptr_q + (POINTER_WIDTH+1)'(put_e);
        rd_ptr_d    = clr ? '0 : rd_ptr_q + (POINTER_WIDTH+1)'(get_e);
        overflow_d  = ~clr & (overflow_q | (put & ~put_e));
        underflow_d = ~clr & (underflow_q | (get & empty));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (put_e & ~clr) mem_q[wr_ptr_q[POINTER_WIDTH-1:0]] <= DataIn;
    end

`ifdef FIFO_QUEUING_FWFT_EN
    assign DataOut = empty ? '0 : mem_q[rd_ptr_q[POINTER_WIDTH-1:0]];
`else
    logic [WIDTH-1:0] data_out_q;

    // Reads the slot before a same-edge write lands, giving read-before-write when full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_out_q <= '0;
        else if (get_e & ~clr) data_out_q <= mem_q[rd_ptr_q[POINTER_WIDTH-1:0]];
    end

    assign DataOut = data_out_q;
`endif
endmodule

// File: tb/tb_fifo_queuing_param.sv
// tb_fifo_queuing_param: queue-model bench with directed scenarios and random traffic.
module tb_fifo_queuing_param;
    localparam int W  = 16;
    localparam int D  = 8;
    localparam int PW = 3;
    localparam int AF = 6;
    localparam int AE = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clr = 1'b0, put = 1'b0, get = 1'b0;
    logic [W-1:0]  DataIn = '0;
    logic [W-1:0]  DataOut;
    logic          empty, QFull, almost_empty, almost_full, overflow, underflow;
    logic [PW:0]   count;

    fifo_queuing_param #(.WIDTH(W), .DEPTH(D), .POINTER_WIDTH(PW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .reset(reset), .clr(clr), .put(put), .get(get), .DataIn(DataIn),
        .DataOut(DataOut), .empty(empty), .QFull(QFull), .almost_empty(almost_empty),
        .almost_full(almost_full), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q[$];
    logic [W-1:0] m_dout = '0;
    logic         m_ovf = 1'b0, m_unf = 1'b0;
    int           n_vec = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_dout();
`ifdef FIFO_QUEUING_FWFT_EN
        return q.size() != 0 ? q[0] : '0;
`else
        return m_dout;
`endif
    endfunction

    always @(negedge clk) begin
        chk("count", 32'(count), q.size());
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("QFull", 32'(QFull), 32'(q.size() == D));
        chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
        chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
        chk("DataOut", 32'(DataOut), 32'(exp_dout()));
    end

    task automatic model_reset();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic g, input logic c, input logic [W-1:0] d);
        logic ge, pe;
        if (c) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ge = g && q.size() != 0;
            pe = p && (q.size() < D || ge);
            if (p && !pe) m_ovf = 1'b1;
            if (g && q.size() == 0) m_unf = 1'b1;
            if (ge) m_dout = q.pop_front();
            if (pe) q.push_back(d);
        end
    endtask

    task automatic step(input logic p, input logic g, input logic c, input logic [W-1:0] d);
        put = p; get = g; clr = c; DataIn = d;
        @(posedge clk);
        model_edge(p, g, c, d);
        @(negedge clk);
        put = 1'b0; get = 1'b0; clr = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_ae", 32'(almost_empty), 1);
        chk("rst_dout", 32'(DataOut), 0);

        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, W'(i));
            chk("fill_count", 32'(count), i);
            chk("fill_af", 32'(almost_full), 32'(i >= 6));
        end
        chk("fill_full", 32'(QFull), 1);
        step(1, 0, 0, 16'h0009);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_count", 32'(count), 8);

        for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_QUEUING_FWFT_EN
            chk("fwft_head", 32'(DataOut), i);
`endif
            step(0, 1, 0, '0);
`ifndef FIFO_QUEUING_FWFT_EN
            chk("drain_dout", 32'(DataOut), i);
`endif
        end
        chk("drain_empty", 32'(empty), 1);
        step(0, 1, 0, '0);
        chk("unf_set", 32'(underflow), 1);
`ifndef FIFO_QUEUING_FWFT_EN
        chk("unf_hold", 32'(DataOut), 8);
`endif
        step(0, 0, 1, '0);
        chk("clr_flags", 32'({overflow, underflow}), 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 5; i++) step(1, 0, 0, W'($urandom));
            for (int i = 0; i < 5; i++) step(0, 1, 0, '0);
            chk("wrap_count", 32'(count), 0);
        end
        chk("wrap_flags", 32'({overflow, underflow}), 0);

        for (int i = 0; i < 8; i++) step(1, 0, 0, W'(16'h0100 + i));
        step(1, 1, 0, 16'h00AA);
        chk("fullpg_count", 32'(count), 8);
        chk("fullpg_ovf", 32'(overflow), 0);
`ifndef FIFO_QUEUING_FWFT_EN
        chk("fullpg_dout", 32'(DataOut), 16'h0100);
`endif
        for (int i = 0; i < 7; i++) step(0, 1, 0, '0);
`ifdef FIFO_QUEUING_FWFT_EN
        chk("fullpg_last", 32'(DataOut), 16'h00AA);
`endif
        step(0, 1, 0, '0);
`ifndef FIFO_QUEUING_FWFT_EN
        chk("fullpg_last", 32'(DataOut), 16'h00AA);
`endif

        step(1, 1, 0, 16'h0055);
        chk("emptypg_count", 32'(count), 1);
        chk("emptypg_unf", 32'(underflow), 1);
        step(1, 0, 1, 16'h0077);
        chk("clrput_count", 32'(count), 0);
        chk("clrput_flags", 32'({overflow, underflow}), 0);

        for (int i = 0; i < 400; i++) begin
            v = W'($urandom);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 40) == 0), v);
        end

        step(0, 0, 1, '0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, W'(16'h0200 + i));
        put = 1'b1; DataIn = 16'h0300;
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_af", 32'(almost_full), 0);
        chk("arst_dout", 32'(DataOut), 0);
        put = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        step(1, 0, 0, 16'h0011);
`ifdef FIFO_QUEUING_FWFT_EN
        chk("fwft_first", 32'(DataOut), 16'h0011);
`else
        chk("std_nofall", 32'(DataOut), 0);
`endif
        step(0, 1, 0, '0);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_queuing_param.md
Name: fifo_queuing_param

Overview:
Parametrised synchronous FIFO queue, the next generation of the team's put/get queue block. Single clock domain buffer between a producer and a consumer. Adds legal simultaneous put+get, occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a synchronous flush. Flags are exact in the same cycle the pointers change, with no one-cycle lag.

Parameters:
WIDTH, 16, data word width in bits
DEPTH, 8, number of entries; must be a power of 2, >= 2
POINTER_WIDTH, 3, log2(DEPTH); address bits into storage
AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  single clock, rising edge
reset  input  1  asynchronous, active-high reset
clr  input  1  synchronous flush; empties queue, clears error flags
put  input  1  write request
get  input  1  read request
DataIn  input  WIDTH  write data, sampled on accepted put
DataOut  output  WIDTH  read data
empty  output  1  count == 0
QFull  output  1  count == DEPTH
almost_empty  output  1  count <= AE_LEVEL
almost_full  output  1  count >= AF_LEVEL
count  output  POINTER_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: put attempted and rejected
underflow  output  1  sticky: get attempted while empty

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high.
- Reset values: wr_ptr=rd_ptr=0, count=0, empty=1, QFull=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, DataOut=0. Storage array is not reset.
- Pointers are POINTER_WIDTH+1 bits wide. Storage is indexed by the low POINTER_WIDTH bits. Pointers wrap modulo 2*DEPTH. count = wr_ptr - rd_ptr, taken modulo 2^(POINTER_WIDTH+1).
- All status outputs decode combinationally from the pointer registers. They reflect a pointer change in the cycle after the accepting edge.
- get_e = get & !empty.
- put_e = put & (!QFull | get_e).
- When full, put+get in the same cycle is legal: both are accepted and count stays at DEPTH.
- When empty, put+get in the same cycle: put is accepted, get is rejected (underflow set), count goes 0 -> 1.
- Accepted put: mem[wr_ptr] <= DataIn; wr_ptr increments.
- Accepted get: DataOut <= mem[rd_ptr] (registered, 1-cycle latency); rd_ptr increments. DataOut holds its value when no get is accepted.
- Full-with-simultaneous-put+get: the read returns the old entry and the write overwrites that slot on the same edge (read-before-write).
- overflow is set on any cycle with put & !put_e. underflow is set on any cycle with get & empty. Both hold until reset or clr.
- clr (synchronous, has priority over put/get in the same cycle): pointers go to 0, overflow and underflow go to 0, DataOut holds, storage is untouched.
- reset asserted mid-operation: all state returns to reset values immediately, and any in-flight put/get is discarded.

Optional Feature:
FIFO_QUEUING_FWFT_EN
- Defined: first-word fall-through. DataOut = mem[rd_ptr] combinationally whenever !empty, and 0 when empty. get pops the entry, so the head word is visible with zero latency. All flag and pointer behaviour is unchanged.
- Undefined: standard mode as above, with a registered DataOut and 1-cycle read latency.

Test Plan:
- Reset, then 8 puts of 0x0001..0x0008 with no get -> count steps 1..8, almost_full rises at count=6, QFull=1 after the 8th edge, overflow=0. A 9th put of 0x0009 -> overflow=1, count stays 8.
- From full, 8 gets -> DataOut 0x0001..0x0008 in order, one cycle after each get; empty=1 at the end. A 9th get -> underflow=1, DataOut holds 0x0008.
- Wrap: 5 puts, 5 gets, repeated 4 times (pointers pass 2*DEPTH) -> data order preserved, count returns to 0 each round, no error flags.
- Full + simultaneous put 0x00AA / get -> DataOut = oldest entry, count=8, no overflow. Then drain 8 -> 0x00AA comes out last.
- Empty + simultaneous put 0x0055 / get -> count=1, underflow=1. clr with put high -> count=0, flags cleared, put ignored.
- Assert reset asynchronously mid-burst at count=4 -> outputs at reset values before the next clk edge. With FIFO_QUEUING_FWFT_EN defined, the first put 0x0011 appears on DataOut with no get issued.
